// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared states, width codes and bus widths for mem_arbiter
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF_RD,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_DONE
    } state_t;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    // Index of the final byte of a transfer; code 11 behaves as a word.
    function automatic logic [1:0] last_idx(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: last_idx = 2'd0;
            WIDTH_HALF: last_idx = 2'd1;
            default:    last_idx = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, load/store and byte-RAM bus bundle for mem_arbiter
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [INST_W-1:0] if_inst;
    logic              mem_req;
    logic              mem_wr;
    logic [1:0]        mem_width;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    logic              stall_if;

    modport slave (
        input  if_req, if_addr, mem_req, mem_wr, mem_width, mem_addr, mem_wdata, ram_din,
        output if_done, if_inst, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout, stall_if
    );

    modport master (
        output if_req, if_addr, mem_req, mem_wr, mem_width, mem_addr, mem_wdata, ram_din,
        input  if_done, if_inst, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout, stall_if
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM arbiter for fetch and load/store; ARB_RR_EN enables round-robin ties
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic [1:0]        r_last;
    logic              r_pend;
    logic              r_adone;
    logic [31:0]       r_wdata;
    logic [31:0]       r_data;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_wr;
    logic [7:0]        r_ram_dout;
    logic              r_if_done;
    logic              r_mem_done;
    logic [INST_W-1:0] r_if_inst;
    logic [31:0]       r_mem_rdata;
    logic              r_stall_if;

    logic              w_grant_mem;
    logic [1:0]        w_cap_idx;
    logic [1:0]        w_next_cnt;
    logic [31:0]       w_cap_data;
    logic [7:0]        w_wr_byte;

`ifdef ARB_RR_EN
    logic r_last_mem;
    assign w_grant_mem = bus.mem_req && (!bus.if_req || !r_last_mem);
`else
    assign w_grant_mem = bus.mem_req;
`endif

    // RAM data lags the address by a cycle, so the byte arriving now belongs to r_cnt-1.
    assign w_cap_idx  = r_cnt - 2'd1;
    assign w_next_cnt = r_cnt + 2'd1;

    always_comb begin
        w_cap_data = r_data;
        case (w_cap_idx)
            2'd0:    w_cap_data[7:0]   = bus.ram_din;
            2'd1:    w_cap_data[15:8]  = bus.ram_din;
            2'd2:    w_cap_data[23:16] = bus.ram_din;
            default: w_cap_data[31:24] = bus.ram_din;
        endcase
    end

    always_comb begin
        case (w_next_cnt)
            2'd0:    w_wr_byte = r_wdata[7:0];
            2'd1:    w_wr_byte = r_wdata[15:8];
            2'd2:    w_wr_byte = r_wdata[23:16];
            default: w_wr_byte = r_wdata[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 2'd0;
            r_last      <= 2'd0;
            r_pend      <= 1'b0;
            r_adone     <= 1'b0;
            r_wdata     <= '0;
            r_data      <= '0;
            r_ram_addr  <= '0;
            r_ram_wr    <= 1'b0;
            r_ram_dout  <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_inst   <= '0;
            r_mem_rdata <= '0;
            r_stall_if  <= 1'b1;
`ifdef ARB_RR_EN
            r_last_mem  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_req || bus.if_req) begin
                        r_cnt   <= 2'd0;
                        r_pend  <= 1'b0;
                        r_adone <= 1'b0;
                        r_data  <= '0;
                        if (w_grant_mem) begin
                            r_ram_addr <= bus.mem_addr;
                            r_last     <= last_idx(bus.mem_width);
                            r_wdata    <= bus.mem_wdata;
                            if (bus.mem_wr) begin
                                r_ram_wr   <= 1'b1;
                                r_ram_dout <= bus.mem_wdata[7:0];
                                r_state    <= ST_MEM_WR;
                            end else begin
                                r_state    <= ST_MEM_RD;
                            end
`ifdef ARB_RR_EN
                            r_last_mem <= 1'b1;
`endif
                        end else begin
                            r_ram_addr <= bus.if_addr;
                            r_last     <= 2'd3;
                            r_state    <= ST_IF_RD;
`ifdef ARB_RR_EN
                            r_last_mem <= 1'b0;
`endif
                        end
                    end
                end
                ST_IF_RD, ST_MEM_RD: begin
                    if (r_pend) r_data <= w_cap_data;
                    r_pend <= 1'b1;
                    if (!r_adone) begin
                        r_cnt <= w_next_cnt;
                        if (r_cnt == r_last) r_adone    <= 1'b1;
                        else                 r_ram_addr <= r_ram_addr + 1'b1;
                    end else begin
                        // Address phase is over; this cycle only collects the last byte.
                        r_state <= ST_DONE;
                        if (r_state == ST_IF_RD) begin
                            r_if_done  <= 1'b1;
                            r_if_inst  <= w_cap_data;
                            r_stall_if <= 1'b0;
                        end else begin
                            r_mem_done  <= 1'b1;
                            r_mem_rdata <= w_cap_data;
                        end
                    end
                end
                ST_MEM_WR: begin
                    if (r_cnt == r_last) begin
                        r_ram_wr   <= 1'b0;
                        r_mem_done <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt      <= w_next_cnt;
                        r_ram_addr <= r_ram_addr + 1'b1;
                        r_ram_dout <= w_wr_byte;
                    end
                end
                ST_DONE: begin
                    r_if_done  <= 1'b0;
                    r_mem_done <= 1'b0;
                    r_stall_if <= 1'b1;
                    r_cnt      <= 2'd0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wr    = r_ram_wr;
    assign bus.ram_dout  = r_ram_dout;
    assign bus.if_done   = r_if_done;
    assign bus.if_inst   = r_if_inst;
    assign bus.mem_done  = r_mem_done;
    assign bus.mem_rdata = r_mem_rdata;
    assign bus.stall_if  = r_stall_if;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (also builds with ARB_RR_EN)
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    int checks = 0;
    int errors = 0;
    bit last_mem = 1'b0;

    // Byte-wide synchronous RAM: data for an address appears one cycle later.
    always @(posedge clk) begin
        bus.ram_din <= ram.exists(bus.ram_addr) ? ram[bus.ram_addr] : 8'h00;
        if (bus.ram_wr) ram[bus.ram_addr] = bus.ram_dout;
    end

    typedef struct {
        bit          do_if;
        logic [31:0] ia;
        bit          do_mem;
        bit          wr;
        logic [1:0]  w;
        logic [31:0] ma;
        logic [31:0] wd;
        logic [31:0] exp_if;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    function automatic logic [7:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int n_of(input logic [1:0] w);
        return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(rd_ref(a + 32'(i))) << (8 * i));
        return v;
    endfunction

    task automatic check_one(input bit is_if, input bit wr, input logic [1:0] w,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] exp_data, input bit second);
        int n = is_if ? 4 : n_of(w);
        int d = (!is_if && wr) ? n + 1 : n + 2;
        bit st = !is_if && wr;
        if (second) begin
            @(negedge clk);
            chk("idle_stall", 32'(bus.stall_if), 32'd1);
            chk("idle_done", {30'd0, bus.if_done, bus.mem_done}, 32'd0);
        end
        for (int j = 1; j <= d; j++) begin
            @(negedge clk);
            if (j <= n) chk($sformatf("addr@T+%0d", j), bus.ram_addr, addr + 32'(j - 1));
            if (st) begin
                chk($sformatf("ram_wr@T+%0d", j), 32'(bus.ram_wr), 32'(j <= n));
                if (j <= n) chk($sformatf("dout@T+%0d", j), 32'(bus.ram_dout), (wd >> (8 * (j - 1))) & 32'hFF);
            end else begin
                chk($sformatf("ram_wr_rd@T+%0d", j), 32'(bus.ram_wr), 32'd0);
            end
            chk($sformatf("if_done@T+%0d", j), 32'(bus.if_done), 32'(is_if && j == d));
            chk($sformatf("mem_done@T+%0d", j), 32'(bus.mem_done), 32'(!is_if && j == d));
            chk($sformatf("stall_if@T+%0d", j), 32'(bus.stall_if), 32'(!(is_if && j == d)));
            if (j == d) begin
                if (is_if) begin
                    chk("if_inst", bus.if_inst, exp_data);
                    bus.if_req = 1'b0;
                end else begin
                    if (!wr) chk("mem_rdata", bus.mem_rdata, exp_data);
                    bus.mem_req = 1'b0;
                end
            end
        end
        if (st) for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wd[8*i +: 8];
    endtask

    task automatic run_txn(input vec_t v);
        bit mem_first;
        @(negedge clk);
        bus.if_req    = v.do_if;
        bus.if_addr   = v.ia;
        bus.mem_req   = v.do_mem;
        bus.mem_wr    = v.wr;
        bus.mem_width = v.w;
        bus.mem_addr  = v.ma;
        bus.mem_wdata = v.wd;
        mem_first = v.do_mem;
`ifdef ARB_RR_EN
        if (v.do_if && v.do_mem) mem_first = !last_mem;
`endif
        if (mem_first) begin
            check_one(1'b0, v.wr, v.w, v.ma, v.wd, v.exp_mem, 1'b0);
            if (v.do_if) check_one(1'b1, 1'b0, 2'b10, v.ia, 32'h0, v.exp_if, 1'b1);
        end else begin
            check_one(1'b1, 1'b0, 2'b10, v.ia, 32'h0, v.exp_if, 1'b0);
            if (v.do_mem) check_one(1'b0, v.wr, v.w, v.ma, v.wd, v.exp_mem, 1'b1);
        end
        last_mem = mem_first ? !v.do_if : v.do_mem;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bus.if_req = 0; bus.if_addr = 0; bus.mem_req = 0; bus.mem_wr = 0;
        bus.mem_width = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h10); poke(32'h103, 8'h00);
        poke(32'h40, 8'h9F);  poke(32'h22, 8'h55);  poke(32'h23, 8'h66);
        poke(32'hFFFFFFFE, 8'h11); poke(32'hFFFFFFFF, 8'h22);
        poke(32'h0, 8'h33); poke(32'h1, 8'h44); poke(32'h2, 8'h55);

        repeat (3) @(negedge clk);
        chk("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
        chk("rst_dones", {30'd0, bus.if_done, bus.mem_done}, 32'd0);
        chk("rst_stall", 32'(bus.stall_if), 32'd1);
        chk("rst_ram_addr", bus.ram_addr, 32'd0);
        chk("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
        chk("rst_if_inst", bus.if_inst, 32'd0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
        rst = 1'b0;

        vecs.push_back(vec_t'{1, 32'h100, 1, 0, 2'b00, 32'h40, 0, 32'h00100513, 32'h0000009F});
        vecs.push_back(vec_t'{1, 32'h100, 1, 0, 2'b00, 32'h40, 0, 32'h00100513, 32'h0000009F});
        vecs.push_back(vec_t'{0, 0, 1, 1, 2'b01, 32'h20, 32'hAABBCCDD, 0, 0});
        vecs.push_back(vec_t'{0, 0, 1, 0, 2'b10, 32'h20, 0, 0, 32'h6655CCDD});
        vecs.push_back(vec_t'{0, 0, 1, 0, 2'b01, 32'h101, 0, 0, 32'h00001005});
        vecs.push_back(vec_t'{0, 0, 1, 0, 2'b10, 32'hFFFFFFFE, 0, 0, 32'h44332211});
        vecs.push_back(vec_t'{0, 0, 1, 1, 2'b00, 32'h300, 32'h123456A5, 0, 0});
        vecs.push_back(vec_t'{0, 0, 1, 0, 2'b10, 32'h300, 0, 0, 32'h000000A5});
        vecs.push_back(vec_t'{1, 32'hFFFFFFFF, 0, 0, 2'b00, 0, 0, 32'h55443322, 0});
        vecs.push_back(vec_t'{0, 0, 1, 0, 2'b11, 32'h100, 0, 0, 32'h00100513});
        foreach (vecs[k]) run_txn(vecs[k]);
        chk("hold_mem_rdata", bus.mem_rdata, 32'h00100513);
        chk("hold_if_inst", bus.if_inst, 32'h55443322);

        // Reset in the middle of a word store: two bytes land, the rest is abandoned.
        @(negedge clk);
        bus.mem_req = 1; bus.mem_wr = 1; bus.mem_width = 2'b10;
        bus.mem_addr = 32'h400; bus.mem_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("abort_wr@T+1", 32'(bus.ram_wr), 32'd1);
        @(negedge clk);
        chk("abort_wr@T+2", 32'(bus.ram_wr), 32'd1);
        chk("abort_addr@T+2", bus.ram_addr, 32'h401);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wr_low", 32'(bus.ram_wr), 32'd0);
        chk("abort_no_done", 32'(bus.mem_done), 32'd0);
        chk("abort_stall", 32'(bus.stall_if), 32'd1);
        bus.mem_req = 0; bus.mem_wr = 0;
        rst = 1'b0;
        last_mem = 1'b0;
        ref_mem[32'h400] = 8'h0D;
        ref_mem[32'h401] = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_quiet", {30'd0, bus.mem_done, bus.ram_wr}, 32'd0);
        end
        v = vec_t'{0, 0, 1, 0, 2'b10, 32'h400, 0, 0, 32'h0000F00D};
        run_txn(v);

        for (int r = 0; r < 40; r++) begin
            v.do_mem = ($urandom % 4) != 0;
            v.do_if  = !v.do_mem || (($urandom % 4) == 0);
            v.ia     = 32'h100 + ($urandom % 4);
            v.wr     = $urandom % 2;
            v.w      = 2'($urandom % 4);
            v.ma     = (($urandom % 5) == 0) ? 32'hFFFFFFF8 + ($urandom % 8) : 32'h500 + ($urandom % 32);
            v.wd     = $urandom;
            v.exp_if  = model_read(v.ia, 4);
            v.exp_mem = model_read(v.ma, n_of(v.w));
            run_txn(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
